// File: rtl/lpc_reg_bank.sv
// rtl/lpc_reg_bank.sv - parametrised LPC I/O register bank with RW/RO/W1C registers and key-sequence lock
module lpc_reg_bank #(
    parameter int                    NUM_REGS       = 32,
    parameter logic [7:0]            BASE_OFFSET    = 8'h00,
    parameter logic [NUM_REGS*8-1:0] RESET_VALUES   = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK        = {{(NUM_REGS-1){1'b0}}, 1'b1},
    parameter logic [NUM_REGS-1:0]   W1C_MASK       = '0,
    parameter logic [NUM_REGS-1:0]   PROT_MASK      = NUM_REGS'(32'h12),
    parameter bit                    LOCK_EN        = 1'b1,
    parameter int                    LOCK_REG       = NUM_REGS-1,
    parameter int                    UNLOCK_TIMEOUT = 33000
) (
    input  logic                    Mclk,
    input  logic                    MainResetN,
    input  logic [15:0]             DevAddr,
    input  logic                    RdDev_En,
    input  logic                    WrDev_En,
    input  logic [7:0]              WrDev_Data,
    input  logic [NUM_REGS*8-1:0]   HwSet,
    input  logic [NUM_REGS*8-1:0]   HwRoData,
    output logic [7:0]              RdDev_Data,
    output logic                    RdDev_Valid,
    output logic [NUM_REGS*8-1:0]   RegOut,
    output logic [NUM_REGS-1:0]     WrStrobe,
    output logic                    WrErr,
    output logic                    Unlocked
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TW = (UNLOCK_TIMEOUT > 1) ? $clog2(UNLOCK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        LOCKED   = 2'b00,
        KEY1     = 2'b01,
        UNLOCKED = 2'b10
    } lock_state_e;

    logic [NUM_REGS*8-1:0] regs_q, regs_d;
    logic [7:0]            rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [NUM_REGS-1:0]   wr_strobe_q, wr_strobe_d;
    logic                  wr_err_q, wr_err_d;
    lock_state_e           state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic [8:0]            off;
    logic                  hit;
    logic [IW-1:0]         idx;
    logic                  is_lock;
    logic                  unlocked;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^DevAddr[15:8];

    // 9-bit subtraction so addresses below BASE_OFFSET show up as a borrow
    assign off      = {1'b0, DevAddr[7:0]} - {1'b0, BASE_OFFSET};
    assign hit      = !off[8] && (off < 9'(NUM_REGS));
    assign idx      = off[IW-1:0];
    assign is_lock  = LOCK_EN && (idx == IW'(LOCK_REG));
    assign unlocked = !LOCK_EN || (state_q == UNLOCKED);

    always_comb begin
        regs_d      = regs_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        wr_strobe_d = '0;
        wr_err_d    = 1'b0;
        state_d     = state_q;
        timer_d     = timer_q;

        for (int i = 0; i < NUM_REGS; i++) begin
            if (W1C_MASK[i]) begin
                regs_d[8*i +: 8] = regs_q[8*i +: 8] | HwSet[8*i +: 8];
            end
        end

        if (state_q == UNLOCKED) begin
            if (timer_q == '0) begin
                state_d = LOCKED;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        // Reads sample regs_q, so a same-cycle write is not visible yet
        if (RdDev_En) begin
            rd_valid_d = 1'b1;
            if (!hit) begin
                rd_data_d = 8'hFF;
            end else if (is_lock) begin
                rd_data_d = {6'b0, state_q};
            end else if (RO_MASK[idx]) begin
                rd_data_d = HwRoData[idx*8 +: 8];
            end else begin
                rd_data_d = regs_q[idx*8 +: 8];
            end
        end

        if (WrDev_En && hit) begin
            if (is_lock) begin
                wr_strobe_d[idx] = 1'b1;
                case (state_q)
                    LOCKED: begin
                        if (WrDev_Data == 8'h5A) state_d = KEY1;
                    end
                    KEY1: begin
                        if (WrDev_Data == 8'hA5) begin
                            state_d = UNLOCKED;
                            timer_d = TW'(UNLOCK_TIMEOUT - 1);
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                    UNLOCKED: begin
                        if (WrDev_Data == 8'h00) state_d = LOCKED;
                    end
                    default: state_d = LOCKED;
                endcase
            end else begin
                if (state_q == KEY1) state_d = LOCKED;
                if (RO_MASK[idx] || (PROT_MASK[idx] && !unlocked)) begin
                    wr_err_d = 1'b1;
                end else begin
                    wr_strobe_d[idx] = 1'b1;
                    if (W1C_MASK[idx]) begin
                        regs_d[idx*8 +: 8] = (regs_q[idx*8 +: 8] & ~WrDev_Data) | HwSet[idx*8 +: 8];
                    end else begin
                        regs_d[idx*8 +: 8] = WrDev_Data;
                    end
                end
            end
        end

        if (!LOCK_EN) begin
            state_d = LOCKED;
            timer_d = '0;
        end
    end

    always_ff @(posedge Mclk or negedge MainResetN) begin
        if (!MainResetN) begin
            regs_q      <= RESET_VALUES;
            rd_data_q   <= 8'hFF;
            rd_valid_q  <= 1'b0;
            wr_strobe_q <= '0;
            wr_err_q    <= 1'b0;
            state_q     <= LOCKED;
            timer_q     <= '0;
        end else begin
            regs_q      <= regs_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            wr_strobe_q <= wr_strobe_d;
            wr_err_q    <= wr_err_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
        end
    end

    assign RdDev_Data  = rd_data_q;
    assign RdDev_Valid = rd_valid_q;
    assign RegOut      = regs_q;
    assign WrStrobe    = wr_strobe_q;
    assign WrErr       = wr_err_q;
    assign Unlocked    = unlocked;

endmodule

// File: tb/tb_lpc_reg_bank.sv
// tb/tb_lpc_reg_bank.sv - scoreboard bench for lpc_reg_bank
module tb_lpc_reg_bank;

    localparam int TMO = 40;

    function automatic logic [255:0] mk_img();
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[8*i +: 8] = 8'(i*7 + 3);
        v[8*5 +: 8]  = 8'h0F;
        v[8*31 +: 8] = 8'h00;
        return v;
    endfunction

    localparam logic [255:0] RST_IMG = mk_img();

    logic         Mclk = 1'b0;
    logic         MainResetN = 1'b0;
    logic [15:0]  DevAddr = '0;
    logic         RdDev_En = 1'b0;
    logic         WrDev_En = 1'b0;
    logic [7:0]   WrDev_Data = '0;
    logic [255:0] HwSet = '0;
    logic [255:0] HwRoData = '0;
    logic [7:0]   RdDev_Data;
    logic         RdDev_Valid;
    logic [255:0] RegOut;
    logic [31:0]  WrStrobe;
    logic         WrErr;
    logic         Unlocked;

    lpc_reg_bank #(
        .NUM_REGS(32), .BASE_OFFSET(8'h00), .RESET_VALUES(RST_IMG),
        .RO_MASK(32'h1), .W1C_MASK(32'h20), .PROT_MASK(32'h12),
        .LOCK_EN(1'b1), .LOCK_REG(31), .UNLOCK_TIMEOUT(TMO)
    ) dut (
        .Mclk(Mclk), .MainResetN(MainResetN), .DevAddr(DevAddr),
        .RdDev_En(RdDev_En), .WrDev_En(WrDev_En), .WrDev_Data(WrDev_Data),
        .HwSet(HwSet), .HwRoData(HwRoData), .RdDev_Data(RdDev_Data),
        .RdDev_Valid(RdDev_Valid), .RegOut(RegOut), .WrStrobe(WrStrobe),
        .WrErr(WrErr), .Unlocked(Unlocked)
    );

    always #5 Mclk = ~Mclk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb_q[$];
    string      tag_q[$];
    logic [7:0] mdl[32];
    logic [1:0] mdl_state;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 32; i++) mdl[i] = RST_IMG[8*i +: 8];
        mdl_state = 2'b00;
    endtask

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
        if (a >= 8'd32) return 8'hFF;
        if (a == 8'd0)  return HwRoData[7:0];
        if (a == 8'd31) return {6'b0, mdl_state};
        return mdl[a[4:0]];
    endfunction

    always @(negedge Mclk) begin
        if (MainResetN && RdDev_Valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 32'(RdDev_Data), 32'hDEAD);
            end else begin
                chk(tag_q.pop_front(), 32'(RdDev_Data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic do_read(input logic [7:0] a, input string tag);
        @(negedge Mclk);
        sb_q.push_back(exp_rd(a));
        tag_q.push_back(tag);
        DevAddr  = {8'h00, a};
        RdDev_En = 1'b1;
        @(negedge Mclk);
        RdDev_En = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic [7:0] hs5,
                            input bit rd, input bit exp_err, input string tag);
        @(negedge Mclk);
        if (rd) begin
            sb_q.push_back(exp_rd(a));
            tag_q.push_back({tag, "_rd"});
        end
        DevAddr      = {8'h00, a};
        WrDev_Data   = d;
        WrDev_En     = 1'b1;
        RdDev_En     = rd;
        HwSet[47:40] = hs5;
        @(negedge Mclk);
        WrDev_En = 1'b0;
        RdDev_En = 1'b0;
        HwSet    = '0;
        chk({tag, "_err"}, 32'(WrErr), 32'(exp_err));
        if (a != 8'd31)
            chk({tag, "_strb"}, WrStrobe, (exp_err || a >= 8'd32) ? 32'h0 : (32'h1 << a));
    endtask

    int cyc;

    initial begin
        HwRoData = '0;
        HwRoData[7:0] = 8'hC3;
        mdl_reset();
        repeat (2) @(negedge Mclk);
        chk("rst_rddata", 32'(RdDev_Data), 32'hFF);
        chk("rst_valid", 32'(RdDev_Valid), 32'h0);
        chk("rst_unlocked", 32'(Unlocked), 32'h0);
        chk("rst_strobe", WrStrobe, 32'h0);
        MainResetN = 1'b1;

        for (int i = 0; i < 32; i++) do_read(8'(i), $sformatf("rd_reset_%0d", i));
        do_read(8'h40, "rd_miss");

        do_write(8'd2, 8'h3C, 8'h00, 1'b0, 1'b0, "wr_rw2");
        mdl[2] = 8'h3C;
        do_read(8'd2, "rd_rw2");
        @(negedge Mclk);
        chk("rd_hold", 32'(RdDev_Data), 32'h3C);
        chk("rd_idle_valid", 32'(RdDev_Valid), 32'h0);
        do_write(8'd2, 8'h44, 8'h00, 1'b1, 1'b0, "rdwr_same");
        mdl[2] = 8'h44;
        do_read(8'd2, "rd_after_rdwr");

        do_write(8'd5, 8'h05, 8'h01, 1'b0, 1'b0, "w1c5");
        mdl[5] = 8'h0B;
        do_read(8'd5, "rd_w1c5");

        do_write(8'd4, 8'h77, 8'h00, 1'b0, 1'b1, "prot4_locked");
        do_read(8'd4, "rd_prot4_locked");
        do_write(8'd31, 8'h5A, 8'h00, 1'b0, 1'b0, "key1");
        mdl_state = 2'b01;
        do_read(8'd31, "rd_state_key1");
        do_write(8'd31, 8'hA5, 8'h00, 1'b0, 1'b0, "key2");
        mdl_state = 2'b10;
        chk("unlocked_after_key", 32'(Unlocked), 32'h1);
        do_read(8'd31, "rd_state_unl");
        do_write(8'd4, 8'h77, 8'h00, 1'b0, 1'b0, "prot4_unl");
        mdl[4] = 8'h77;
        do_read(8'd4, "rd_prot4_unl");
        do_write(8'd0, 8'h12, 8'h00, 1'b0, 1'b1, "ro0");
        do_write(8'd31, 8'h00, 8'h00, 1'b0, 1'b0, "relock");
        mdl_state = 2'b00;
        chk("locked_after_00", 32'(Unlocked), 32'h0);

        do_write(8'd31, 8'h5A, 8'h00, 1'b0, 1'b0, "bad_key1");
        do_write(8'd2, 8'h99, 8'h00, 1'b0, 1'b0, "bad_mid");
        mdl[2] = 8'h99;
        do_write(8'd31, 8'hA5, 8'h00, 1'b0, 1'b0, "bad_key2");
        chk("bad_seq_locked", 32'(Unlocked), 32'h0);
        do_read(8'd31, "rd_state_bad");
        do_read(8'd2, "rd_bad_mid");

        do_write(8'd31, 8'h5A, 8'h00, 1'b0, 1'b0, "tmo_key1");
        do_write(8'd31, 8'hA5, 8'h00, 1'b0, 1'b0, "tmo_key2");
        cyc = Unlocked ? 1 : 0;
        for (int g = 0; g < TMO + 10 && Unlocked; g++) begin
            @(negedge Mclk);
            if (Unlocked) cyc++;
        end
        chk("unlock_cycles", 32'(cyc), 32'(TMO));
        chk("timeout_locked", 32'(Unlocked), 32'h0);

        do_write(8'd31, 8'h5A, 8'h00, 1'b0, 1'b0, "rst_key1");
        do_write(8'd31, 8'hA5, 8'h00, 1'b0, 1'b0, "rst_key2");
        chk("pre_rst_unlocked", 32'(Unlocked), 32'h1);
        do_read(8'd2, "rd_pre_rst");
        @(negedge Mclk);
        DevAddr    = 16'h0002;
        WrDev_Data = 8'h55;
        WrDev_En   = 1'b1;
        #2 MainResetN = 1'b0;
        @(negedge Mclk);
        WrDev_En = 1'b0;
        chk("midrst_unlocked", 32'(Unlocked), 32'h0);
        chk("midrst_rddata", 32'(RdDev_Data), 32'hFF);
        chk("midrst_strobe", WrStrobe, 32'h0);
        chk("midrst_reg2", 32'(RegOut[23:16]), 32'h11);
        chk("midrst_reg5", 32'(RegOut[47:40]), 32'h0F);
        @(negedge Mclk);
        MainResetN = 1'b1;
        mdl_reset();
        do_read(8'd2, "rd_post_rst2");
        do_read(8'd4, "rd_post_rst4");
        do_read(8'd31, "rd_post_rst_state");

        repeat (3) @(negedge Mclk);
        chk("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
